// File: rtl/intr_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : intr_timer_ctrl
//  Purpose  : Bus-mapped 64-bit machine timer plus prioritised external
//             interrupt sources with claim/complete handshake.
//  Revision : 1.0  initial release
// ============================================================================
module intr_timer_ctrl #(
    parameter int DW          = 32,
    parameter int ADDRW       = 12,
    parameter int NUM_EXT     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ADDRW-1:0]   addr_i,
    input  logic               wr_en_i,
    input  logic               rd_en_i,
    input  logic [DW-1:0]      wdata_i,
    output logic [DW-1:0]      rdata_o,
    input  logic [NUM_EXT-1:0] ext_irq_i,
    output logic               t_intr_o,
    output logic               e_intr_o,
    output logic [4:0]         e_intr_id_o
);
    localparam logic [3:0] c_MTIME_LO    = 4'd0;
    localparam logic [3:0] c_MTIME_HI    = 4'd1;
    localparam logic [3:0] c_MTIMECMP_LO = 4'd2;
    localparam logic [3:0] c_MTIMECMP_HI = 4'd3;
    localparam logic [3:0] c_PRESCALE    = 4'd4;
    localparam logic [3:0] c_IE          = 4'd5;
    localparam logic [3:0] c_MODE        = 4'd6;
    localparam logic [3:0] c_PENDING     = 4'd7;
    localparam logic [3:0] c_CLAIM       = 4'd8;

    logic [63:0]        r_mtime;
    logic [63:0]        r_mtimecmp;
    logic [DW-1:0]      r_prescale;
    logic [DW-1:0]      r_pscnt;
    logic [NUM_EXT-1:0] r_ie;
    logic [NUM_EXT-1:0] r_mode;
    logic [NUM_EXT-1:0] r_pending;
    logic [NUM_EXT-1:0] r_in_service;
    logic [NUM_EXT-1:0] r_sync [SYNC_STAGES];
    logic [NUM_EXT-1:0] r_sync_d;
    logic               r_t_intr;
    logic               r_e_intr;
    logic [DW-1:0]      r_rdata;

    logic [3:0]         w_off;
    logic               w_tick;
    logic [NUM_EXT-1:0] w_sync;
    logic [NUM_EXT-1:0] w_rise;
    logic [NUM_EXT-1:0] w_elig;
    logic [4:0]         w_id;
    logic               w_claim_rd;
    logic               w_wr_claim;
    logic [NUM_EXT-1:0] w_claim_mask;
    logic [NUM_EXT-1:0] w_complete_mask;
    logic [NUM_EXT-1:0] w_w1c;
    logic [NUM_EXT-1:0] w_pend_next;
    logic [DW-1:0]      w_rdata;
    logic               w_unused_addr;

    assign w_off         = addr_i[5:2];
    assign w_unused_addr = ^{addr_i[ADDRW-1:6], addr_i[1:0]};
    assign w_tick        = (r_pscnt == r_prescale);
    assign w_sync        = r_sync[SYNC_STAGES-1];
    assign w_rise        = w_sync & ~r_sync_d;
    assign w_elig        = r_pending & r_ie & ~r_in_service;
    assign w_claim_rd    = rd_en_i && (w_off == c_CLAIM) && (w_id != 5'd0);
    assign w_wr_claim    = wr_en_i && (w_off == c_CLAIM);
    assign w_w1c         = (wr_en_i && (w_off == c_PENDING)) ? wdata_i[NUM_EXT-1:0] : '0;

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        w_id = 5'd0;
        for (int i = NUM_EXT - 1; i >= 0; i--) begin
            if (w_elig[i]) w_id = 5'(i + 1);
        end
    end

    always_comb begin
        w_claim_mask    = '0;
        w_complete_mask = '0;
        for (int i = 0; i < NUM_EXT; i++) begin
            w_claim_mask[i]    = w_claim_rd && (w_id == 5'(i + 1));
            w_complete_mask[i] = w_wr_claim && (wdata_i == DW'(i + 1)) && r_in_service[i];
        end
    end

    // Edge lines: a same-cycle set beats any clear. Level lines follow the input.
    assign w_pend_next = (r_mode & ((r_pending & ~(w_w1c | w_claim_mask)) | w_rise))
                       | (~r_mode & w_sync);

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_MTIME_LO:    w_rdata = r_mtime[31:0];
            c_MTIME_HI:    w_rdata = r_mtime[63:32];
            c_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
            c_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
            c_PRESCALE:    w_rdata = r_prescale;
            c_IE:          w_rdata = DW'(r_ie);
            c_MODE:        w_rdata = DW'(r_mode);
            c_PENDING:     w_rdata = DW'(r_pending);
            c_CLAIM:       w_rdata = DW'(w_id);
            default:       w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_mtime      <= '0;
            r_mtimecmp   <= '1;
            r_prescale   <= '0;
            r_pscnt      <= '0;
            r_ie         <= '0;
            r_mode       <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_sync_d     <= '0;
            r_t_intr     <= 1'b0;
            r_e_intr     <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_sync[0] <= ext_irq_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_sync_d  <= w_sync;

            r_pscnt <= w_tick ? '0 : r_pscnt + DW'(1);
            // A write to either half suppresses that cycle's increment entirely.
            if (wr_en_i && (w_off == c_MTIME_LO))      r_mtime[31:0]  <= wdata_i;
            else if (wr_en_i && (w_off == c_MTIME_HI)) r_mtime[63:32] <= wdata_i;
            else if (w_tick)                           r_mtime        <= r_mtime + 64'd1;

            if (wr_en_i && (w_off == c_MTIMECMP_LO)) r_mtimecmp[31:0]  <= wdata_i;
            if (wr_en_i && (w_off == c_MTIMECMP_HI)) r_mtimecmp[63:32] <= wdata_i;
            if (wr_en_i && (w_off == c_PRESCALE))    r_prescale        <= wdata_i;
            if (wr_en_i && (w_off == c_IE))          r_ie              <= wdata_i[NUM_EXT-1:0];
            if (wr_en_i && (w_off == c_MODE))        r_mode            <= wdata_i[NUM_EXT-1:0];

            r_t_intr     <= (r_mtime >= r_mtimecmp);
            r_e_intr     <= (w_id != 5'd0);
            r_pending    <= w_pend_next;
            r_in_service <= (r_in_service & ~w_complete_mask) | w_claim_mask;
            if (rd_en_i) r_rdata <= w_rdata;
        end
    end

    assign rdata_o     = r_rdata;
    assign t_intr_o    = r_t_intr;
    assign e_intr_o    = r_e_intr;
    assign e_intr_id_o = w_id;

endmodule
`default_nettype wire

// File: tb/tb_intr_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_intr_timer_ctrl
//  Purpose  : Directed scenarios plus random traffic against a cycle model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_intr_timer_ctrl;
    localparam int DW      = 32;
    localparam int ADDRW   = 12;
    localparam int NUM_EXT = 8;
    localparam int S       = 2;

    localparam logic [3:0] O_MTLO = 4'd0, O_MTHI = 4'd1, O_CMPLO = 4'd2, O_CMPHI = 4'd3;
    localparam logic [3:0] O_PRE = 4'd4, O_IE = 4'd5, O_MODE = 4'd6, O_PEND = 4'd7, O_CLAIM = 4'd8;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic [ADDRW-1:0]   addr_i;
    logic               wr_en_i;
    logic               rd_en_i;
    logic [DW-1:0]      wdata_i;
    logic [DW-1:0]      rdata_o;
    logic [NUM_EXT-1:0] ext_irq_i;
    logic               t_intr_o;
    logic               e_intr_o;
    logic [4:0]         e_intr_id_o;

    always #5 clk_i = ~clk_i;

    intr_timer_ctrl #(.DW(DW), .ADDRW(ADDRW), .NUM_EXT(NUM_EXT), .SYNC_STAGES(S)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .wr_en_i(wr_en_i),
        .rd_en_i(rd_en_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .ext_irq_i(ext_irq_i),
        .t_intr_o(t_intr_o), .e_intr_o(e_intr_o), .e_intr_id_o(e_intr_id_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: mtime as a plain 64-bit integer, synchroniser as an input history.
    longint unsigned    m_mtime, m_cmp;
    int unsigned        m_pre, m_cnt;
    logic [NUM_EXT-1:0] m_ie, m_mode, m_pend, m_insvc;
    logic [NUM_EXT-1:0] m_hist [0:S];
    logic               m_t, m_e;
    logic [31:0]        m_rdata;

    function automatic int unsigned model_id();
        for (int i = 0; i < NUM_EXT; i++)
            if (m_pend[i] && m_ie[i] && !m_insvc[i]) return i + 1;
        return 0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0]         off;
        int unsigned        id;
        logic [NUM_EXT-1:0] clr;
        logic [31:0]        rv;
        logic               tick;
        if (!rst_ni) begin
            m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_pre = 0; m_cnt = 0;
            m_ie = '0; m_mode = '0; m_pend = '0; m_insvc = '0;
            for (int k = 0; k <= S; k++) m_hist[k] = '0;
            m_t = 0; m_e = 0; m_rdata = 0;
            return;
        end
        off = addr_i[5:2];
        id  = model_id();
        case (off)
            O_MTLO:  rv = m_mtime[31:0];
            O_MTHI:  rv = m_mtime[63:32];
            O_CMPLO: rv = m_cmp[31:0];
            O_CMPHI: rv = m_cmp[63:32];
            O_PRE:   rv = m_pre;
            O_IE:    rv = 32'(m_ie);
            O_MODE:  rv = 32'(m_mode);
            O_PEND:  rv = 32'(m_pend);
            O_CLAIM: rv = id;
            default: rv = 0;
        endcase
        m_t  = (m_mtime >= m_cmp);
        m_e  = (id != 0);
        tick = (m_cnt == m_pre);
        m_cnt = tick ? 0 : m_cnt + 1;
        if (wr_en_i && off == O_MTLO)      m_mtime = {m_mtime[63:32], wdata_i};
        else if (wr_en_i && off == O_MTHI) m_mtime = {wdata_i, m_mtime[31:0]};
        else if (tick)                     m_mtime = m_mtime + 1;
        clr = (wr_en_i && off == O_PEND) ? wdata_i[NUM_EXT-1:0] : '0;
        if (rd_en_i && off == O_CLAIM && id != 0) clr[id-1] = 1'b1;
        for (int i = 0; i < NUM_EXT; i++) begin
            if (m_mode[i]) m_pend[i] = (m_pend[i] & ~clr[i]) | (m_hist[S-1][i] & ~m_hist[S][i]);
            else           m_pend[i] = m_hist[S-1][i];
        end
        if (wr_en_i && off == O_CLAIM && wdata_i >= 1 && wdata_i <= NUM_EXT) m_insvc[wdata_i-1] = 1'b0;
        if (rd_en_i && off == O_CLAIM && id != 0) m_insvc[id-1] = 1'b1;
        for (int k = S; k >= 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = ext_irq_i;
        if (wr_en_i && off == O_CMPLO) m_cmp = {m_cmp[63:32], wdata_i};
        if (wr_en_i && off == O_CMPHI) m_cmp = {wdata_i, m_cmp[31:0]};
        if (wr_en_i && off == O_PRE)   m_pre = wdata_i;
        if (wr_en_i && off == O_IE)    m_ie = wdata_i[NUM_EXT-1:0];
        if (wr_en_i && off == O_MODE)  m_mode = wdata_i[NUM_EXT-1:0];
        if (rd_en_i) m_rdata = rv;
    endtask

    // One clock: advance the model at the edge, compare every output mid-cycle.
    task automatic cycle();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
        check("t_intr", t_intr_o, m_t);
        check("e_intr", e_intr_o, m_e);
        check("e_id", e_intr_id_o, model_id());
        check("rdata", rdata_o, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic bus(input logic wr, input logic rd, input logic [3:0] off, input logic [31:0] d);
        addr_i = {6'b0, off, 2'b00}; wr_en_i = wr; rd_en_i = rd; wdata_i = d;
        cycle();
        wr_en_i = 1'b0; rd_en_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
    endtask

    initial begin
        int          n;
        int unsigned idx;
        logic [3:0]  off;
        logic [31:0] d;
        addr_i = '0; wr_en_i = 0; rd_en_i = 0; wdata_i = '0; ext_irq_i = '0; rst_ni = 1'b0;

        // Reset values
        do_reset();
        check("rst_t", t_intr_o, 0);
        check("rst_e", e_intr_o, 0);
        check("rst_id", e_intr_id_o, 0);
        check("rst_rdata", rdata_o, 0);

        // Timer compare, PRESCALE=0
        bus(1, 0, O_MTLO, 0);
        bus(1, 0, O_CMPLO, 20);
        bus(1, 0, O_CMPHI, 0);
        n = 0;
        while (!t_intr_o && n < 60) begin idle(1); n++; end
        check("t_rise_bound", (n < 60), 1);
        bus(0, 1, O_MTLO, 0);
        check("mtime_at_rise", rdata_o, 21);
        bus(1, 0, O_CMPHI, 1);
        check("t_hold", t_intr_o, 1);
        idle(1);
        check("t_drop", t_intr_o, 0);

        // Prescaler and LO->HI carry
        do_reset();
        bus(1, 0, O_PRE, 3);
        bus(1, 0, O_MTHI, 0);
        bus(1, 0, O_MTLO, 32'hFFFF_FFFE);
        idle(6);
        bus(0, 1, O_MTLO, 0);
        check("carry_lo", rdata_o, 0);
        bus(0, 1, O_MTHI, 0);
        check("carry_hi", rdata_o, 1);

        // Edge mode priority and claim/complete
        do_reset();
        bus(1, 0, O_IE, 32'h0A);
        bus(1, 0, O_MODE, 32'h0A);
        ext_irq_i[3] = 1'b1; idle(2); ext_irq_i[3] = 1'b0; idle(1);
        ext_irq_i[1] = 1'b1; idle(2); ext_irq_i[1] = 1'b0; idle(4);
        check("edge_id", e_intr_id_o, 2);
        check("edge_e", e_intr_o, 1);
        bus(0, 1, O_CLAIM, 0);
        check("claim_rd", rdata_o, 2);
        check("claim_next_id", e_intr_id_o, 4);
        bus(1, 0, O_CLAIM, 2);
        idle(1);
        check("complete_no_edge", e_intr_id_o, 4);
        ext_irq_i[1] = 1'b1; idle(2); ext_irq_i[1] = 1'b0; idle(3);
        check("new_edge_id", e_intr_id_o, 2);

        // Level mode latency, claim and re-raise
        do_reset();
        bus(1, 0, O_IE, 32'h01);
        ext_irq_i[0] = 1'b1;
        n = 0;
        while (!e_intr_o && n < 20) begin idle(1); n++; end
        check("lvl_latency_ok", (n == S + 1 || n == S + 2), 1);
        bus(0, 1, O_CLAIM, 0);
        check("lvl_claim", rdata_o, 1);
        idle(1);
        check("lvl_drop", e_intr_o, 0);
        bus(1, 0, O_CLAIM, 1);
        check("lvl_pre_reraise", e_intr_o, 0);
        idle(1);
        check("lvl_reraise", e_intr_o, 1);

        // Rising edge concurrent with W1C; bogus completes
        ext_irq_i = '0;
        do_reset();
        bus(1, 0, O_IE, 32'h05);
        bus(1, 0, O_MODE, 32'h04);
        ext_irq_i[2] = 1'b1; idle(S);
        bus(1, 0, O_PEND, 32'h04);
        bus(0, 1, O_PEND, 0);
        check("set_beats_w1c", rdata_o, 32'h04);
        bus(1, 0, O_PEND, 32'h04);
        bus(0, 1, O_PEND, 0);
        check("w1c_clears", rdata_o, 0);
        ext_irq_i[0] = 1'b1; idle(S + 2);
        bus(0, 1, O_CLAIM, 0);
        check("claim_lvl0", rdata_o, 1);
        bus(1, 0, O_CLAIM, 9);
        idle(2);
        check("claim9_id", e_intr_id_o, 0);
        check("claim9_e", e_intr_o, 0);
        bus(1, 0, O_CLAIM, 0);
        idle(2);
        check("claim0_id", e_intr_id_o, 0);

        // Reset during outstanding claim with timer asserted
        bus(1, 0, O_CMPLO, 0);
        bus(1, 0, O_CMPHI, 0);
        idle(2);
        check("pre_rst_t", t_intr_o, 1);
        do_reset();
        check("mid_rst_t", t_intr_o, 0);
        check("mid_rst_e", e_intr_o, 0);
        check("mid_rst_id", e_intr_id_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        bus(0, 1, O_CMPLO, 0);
        check("cmp_lo_rst", rdata_o, 32'hFFFF_FFFF);
        bus(0, 1, O_CMPHI, 0);
        check("cmp_hi_rst", rdata_o, 32'hFFFF_FFFF);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst_ni = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, NUM_EXT - 1);
                ext_irq_i[idx] = ~ext_irq_i[idx];
            end
            off = 4'($urandom_range(0, 15));
            case (off)
                O_MTLO, O_CMPLO: d = $urandom_range(0, 200);
                O_MTHI, O_CMPHI: d = $urandom_range(0, 1);
                O_PRE:           d = $urandom_range(0, 3);
                O_CLAIM:         d = $urandom_range(0, 10);
                default:         d = $urandom;
            endcase
            addr_i  = {6'($urandom), off, 2'($urandom)};
            wr_en_i = ($urandom_range(0, 2) == 0);
            rd_en_i = ($urandom_range(0, 1) == 0);
            wdata_i = d;
            cycle();
        end
        rst_ni = 1'b1; wr_en_i = 0; rd_en_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
